// File: rtl/tcbm_drive_link.sv
`default_nettype none
// ============================================================================
// Module   : tcbm_drive_link
// Purpose  : Drive-side TCBM paddle-bus protocol engine. Accepts a code byte
//            and one data byte per transaction from the host, answers with
//            ACK and status, and streams bytes to/from the drive controller.
// Revision : 1.0  initial release
// ============================================================================
module tcbm_drive_link #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] dat_i,
  output logic [7:0] dat_o,
  output logic       dat_oe,
  input  logic       dav_n,
  output logic       ack_n,
  output logic [1:0] st_o,
  output logic [7:0] rx_data,
  output logic       rx_cmd,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [1:0] rx_status,
  input  logic [7:0] tx_data,
  input  logic [1:0] tx_status,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       err
);

  localparam int            CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CODE_CMD  = 8'h81;
  localparam logic [7:0] CODE_DATA = 8'h83;
  localparam logic [7:0] CODE_TALK = 8'h84;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CODE_ACK  = 3'd1;
  localparam logic [2:0] S_DATA_WAIT = 3'd2;
  localparam logic [2:0] S_RX_HOLD   = 3'd3;
  localparam logic [2:0] S_RX_ACK    = 3'd4;
  localparam logic [2:0] S_TX_WAIT   = 3'd5;
  localparam logic [2:0] S_TX_ACK    = 3'd6;
  localparam logic [2:0] S_ABORT     = 3'd7;

  logic [2:0]       state;
  logic [7:0]       code;
  logic             dav_meta;
  logic             dav_s;
  logic [CNT_W-1:0] tmo_cnt;
  logic             cnt_en;
  logic             leaving;
  logic             timeout_hit;

  assign busy = (state != S_IDLE);

  // Two-flop synchronizer for the asynchronous host DAV strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      dav_meta <= 1'b1;
      dav_s    <= 1'b1;
    end else begin
      dav_meta <= dav_n;
      dav_s    <= dav_meta;
    end
  end

  // Decide whether the host-wait timer runs and whether this cycle expires it;
  // a state exit in the same cycle takes priority over the timeout.
  always_comb begin
    cnt_en  = 1'b0;
    leaving = 1'b0;
    case (state)
      S_CODE_ACK, S_RX_ACK, S_TX_ACK: begin
        cnt_en  = 1'b1;
        leaving = dav_s;
      end
      S_DATA_WAIT: begin
        cnt_en  = 1'b1;
        leaving = ~dav_s;
      end
      default: begin
        cnt_en  = 1'b0;
        leaving = 1'b0;
      end
    endcase
    timeout_hit = cnt_en && !leaving && (tmo_cnt == CNT_LAST);
  end

  // Protocol state machine, host-side handshake outputs and timeout counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      code     <= 8'h00;
      tmo_cnt  <= '0;
      ack_n    <= 1'b1;
      dat_oe   <= 1'b0;
      dat_o    <= 8'h00;
      st_o     <= 2'b00;
      rx_data  <= 8'h00;
      rx_cmd   <= 1'b0;
      rx_valid <= 1'b0;
      tx_ready <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      if (cnt_en) begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (!dav_s) begin
            code    <= dat_i;
            ack_n   <= 1'b0;
            state   <= S_CODE_ACK;
            tmo_cnt <= '0;
          end
        end
        S_CODE_ACK: begin
          if (dav_s) begin
            ack_n   <= 1'b1;
            tmo_cnt <= '0;
            if (code == CODE_CMD || code == CODE_DATA || code == CODE_TALK) begin
              state <= S_DATA_WAIT;
            end else begin
              err   <= 1'b1;
              state <= S_IDLE;
            end
          end
        end
        S_DATA_WAIT: begin
          if (!dav_s) begin
            tmo_cnt <= '0;
            if (code == CODE_TALK) begin
              tx_ready <= 1'b1;
              state    <= S_TX_WAIT;
            end else begin
              rx_data  <= dat_i;
              rx_cmd   <= (code == CODE_CMD);
              rx_valid <= 1'b1;
              state    <= S_RX_HOLD;
            end
          end
        end
        S_RX_HOLD: begin
          if (rx_ready && rx_valid) begin
            rx_valid <= 1'b0;
            st_o     <= rx_status;
            ack_n    <= 1'b0;
            state    <= S_RX_ACK;
            tmo_cnt  <= '0;
          end
        end
        S_RX_ACK: begin
          if (dav_s) begin
            ack_n   <= 1'b1;
            state   <= S_IDLE;
            tmo_cnt <= '0;
          end
        end
        S_TX_WAIT: begin
          if (tx_valid) begin
            dat_o    <= tx_data;
            dat_oe   <= 1'b1;
            st_o     <= tx_status;
            ack_n    <= 1'b0;
            tx_ready <= 1'b0;
            state    <= S_TX_ACK;
            tmo_cnt  <= '0;
          end
        end
        S_TX_ACK: begin
          if (dav_s) begin
            ack_n   <= 1'b1;
            dat_oe  <= 1'b0;
            state   <= S_IDLE;
            tmo_cnt <= '0;
          end
        end
        default: begin
          // ABORT: bus released, wait for the host to drop its strobe.
          ack_n  <= 1'b1;
          dat_oe <= 1'b0;
          if (dav_s) begin
            state   <= S_IDLE;
            tmo_cnt <= '0;
          end
        end
      endcase

      if (timeout_hit) begin
        err      <= 1'b1;
        rx_valid <= 1'b0;
        tx_ready <= 1'b0;
        dat_oe   <= 1'b0;
        st_o     <= 2'b00;
        ack_n    <= 1'b1;
        state    <= S_ABORT;
        tmo_cnt  <= '0;
      end
    end
  end

endmodule
`default_nettype wire
